// File: rtl/rv_word_memory_if.sv
// Core-side data memory bus: chip select, direction, word index and a shared tristate data bus.
// The master (core/LSU) drives data on writes; the slave (memory) drives it on reads.
interface rv_word_memory_if #(
   parameter int DATA_W = 32
);
   logic              enable_mem;
   logic              we;
   logic [31:0]       addr;
   wire  [DATA_W-1:0] data;

   modport master (
      output enable_mem,
      output we,
      output addr,
      inout  data
   );

   modport slave (
      input  enable_mem,
      input  we,
      input  addr,
      inout  data
   );
endinterface

// File: rtl/rv_word_memory.sv
// Word-organised single-port data RAM on a shared bidirectional bus; writes land on the rising
// edge, reads are combinational (zero latency); no backpressure, the bus is released unless reading.
module rv_word_memory #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input logic              clk,
   input logic              rst,
   rv_word_memory_if.slave  bus
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              wr_en;
   logic              rd_en;
   logic              unused_addr_hi;

   // Upper address bits are deliberately ignored, so indices wrap modulo DEPTH.
   assign idx            = bus.addr[IDX_W-1:0];
   assign unused_addr_hi = ^bus.addr[31:IDX_W];

   assign wr_en = bus.enable_mem & bus.we;
   assign rd_en = rst & bus.enable_mem & ~bus.we;

   // Reset has priority, so a write presented on the reset edge is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[idx] <= bus.data;
      end
   end

   // Drive only while reading; during writes the core owns the bus.
   assign bus.data = rd_en ? mem[idx] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rv_word_memory.sv
// Self-checking bench for rv_word_memory: directed scenarios plus randomized traffic against an array model.
// Bus release is observed by driving a known value from the bench and expecting it back unaltered.
module tb_rv_word_memory;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 1024;
   localparam int IDX_W  = 10;

   logic              clk;
   logic              rst;
   logic              tb_drv;
   logic [DATA_W-1:0] tb_dat;
   logic [DATA_W-1:0] model [DEPTH];
   int                checks;
   int                errors;

   rv_word_memory_if #(.DATA_W(DATA_W)) bus ();

   assign bus.data = tb_drv ? tb_dat : {DATA_W{1'bz}};

   rv_word_memory #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom();
      // Small index pool so reads hit written words; upper bits random to exercise wrap.
      a = (a & ~(DEPTH - 1)) | $urandom_range(0, 15);
      return a;
   endfunction

   task automatic clear_model();
      foreach (model[i]) model[i] = '0;
   endtask

   // Each operation starts 1ns after a rising edge and ends 1ns after the next one.
   task automatic do_write(input logic [31:0] a, input logic [DATA_W-1:0] d);
      bus.enable_mem = 1'b1;
      bus.we         = 1'b1;
      bus.addr       = a;
      tb_drv         = 1'b1;
      tb_dat         = d;
      #1 check("wr_bus_release", bus.data, d);
      @(posedge clk);
      #1;
      model[a % DEPTH] = d;
   endtask

   task automatic do_read(input string tag, input logic [31:0] a);
      logic [31:0] a2;
      bus.enable_mem = 1'b1;
      bus.we         = 1'b0;
      bus.addr       = a;
      tb_drv         = 1'b0;
      #1 check(tag, bus.data, model[a % DEPTH]);
      a2       = rand_addr();
      bus.addr = a2;
      #1 check("rd_follow_addr", bus.data, model[a2 % DEPTH]);
      @(posedge clk);
      #1;
   endtask

   task automatic do_idle(input logic w, input logic [31:0] a, input logic [DATA_W-1:0] d);
      bus.enable_mem = 1'b0;
      bus.we         = w;
      bus.addr       = a;
      tb_drv         = 1'b1;
      tb_dat         = d;
      #1 check("idle_bus_release", bus.data, d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en, input logic w, input logic [31:0] a, input logic [DATA_W-1:0] d);
      rst            = 1'b0;
      bus.enable_mem = en;
      bus.we         = w;
      bus.addr       = a;
      tb_drv         = 1'b1;
      tb_dat         = d;
      #1 check("rst_bus_release", bus.data, d);
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b0;
      bus.enable_mem = 1'b0;
      bus.we         = 1'b0;
      bus.addr       = '0;
      tb_drv         = 1'b0;
      tb_dat         = '0;
      clear_model();

      @(posedge clk);
      #1;
      do_reset(1'b1, 1'b0, 32'd7, 32'h0);
      do_read("reset_state_w0", 32'd0);
      do_read("reset_state_w7", 32'd7);

      // Reset clears a written word; a read request during reset must not drive the bus.
      do_write(32'd7, 32'h1234_5678);
      do_read("pre_reset_w7", 32'd7);
      do_reset(1'b1, 1'b0, 32'd7, 32'h0);
      do_read("post_reset_w7", 32'd7);

      do_write(32'd2, 32'hABCD_1234);
      do_read("wr_rd_w2", 32'd2);

      do_write(32'd4, 32'hDEAD_BEEF);
      do_read("wr_rd_w4", 32'd4);
      do_read("w2_unchanged", 32'd2);

      do_idle(1'b0, 32'd2, 32'h0);
      do_idle(1'b1, 32'd2, 32'h5555_5555);
      do_read("idle_no_write_w2", 32'd2);

      do_write(DEPTH + 3, 32'hCAFE_F00D);
      do_read("wrap_w3", 32'd3);

      // Write presented on the reset edge is discarded.
      do_write(32'd5, 32'h0000_0077);
      do_reset(1'b1, 1'b1, 32'd5, 32'h0000_0001);
      do_read("rst_mid_write_w5", 32'd5);
      do_read("rst_mid_write_w3", 32'd3);

      for (int n = 0; n < 600; n++) begin
         int op;
         op = $urandom_range(0, 99);
         if (op < 40)      do_write(rand_addr(), $urandom());
         else if (op < 80) do_read("rand_read", rand_addr());
         else if (op < 97) do_idle(1'($urandom_range(0, 1)), rand_addr(), $urandom());
         else              do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
